// File: rtl/delay_line_prog_if.sv
// rtl/delay_line_prog_if.sv - control, data and status bundle for the programmable delay line
//
// Purpose: carries every non-clock, non-reset signal of delay_line_prog.
// master modport: the producer / controller side (drives stall, flush,
//                 cfg_we, cfg_delay, in_valid, in_data; observes the rest).
// slave  modport: the delay line itself.
// Signals:
//   stall      1                     freeze all delay-line state
//   flush      1                     drop every sample in flight
//   cfg_we     1                     load cfg_delay (also flushes)
//   cfg_delay  $clog2(MAX_DELAY+1)   requested delay in cycles
//   in_valid   1                     qualifies in_data
//   in_data    CHANNELS*WIDTH        lane k at [k*WIDTH +: WIDTH]
//   out_valid  1                     qualifies out_data
//   out_data   CHANNELS*WIDTH        delayed lanes, same packing
//   cur_delay  $clog2(MAX_DELAY+1)   delay in effect
//   in_flight  $clog2(MAX_DELAY+1)   accepted samples still in the line
interface delay_line_prog_if #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int MAX_DELAY = 16
);
    localparam int DW     = $clog2(MAX_DELAY + 1);
    localparam int DATA_W = CHANNELS * WIDTH;

    logic              stall;
    logic              flush;
    logic              cfg_we;
    logic [DW-1:0]     cfg_delay;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [DW-1:0]     cur_delay;
    logic [DW-1:0]     in_flight;

    modport master (
        output stall, flush, cfg_we, cfg_delay, in_valid, in_data,
        input  out_valid, out_data, cur_delay, in_flight
    );

    modport slave (
        input  stall, flush, cfg_we, cfg_delay, in_valid, in_data,
        output out_valid, out_data, cur_delay, in_flight
    );
endinterface

// File: rtl/delay_line_prog.sv
// rtl/delay_line_prog.sv - multi-lane delay line with run-time programmable delay
//
// Purpose: every lane of in_data is delayed by the same programmable number
// of advances (cur_delay, 1..MAX_DELAY). Storage is a MAX_DELAY-entry
// circular buffer with a valid bit per entry, followed by an output register.
// Ports:
//   clk  - the only clock, rising edge
//   rst  - synchronous, active-high; restores DEFAULT_DELAY and empties the line
//   bus  - delay_line_prog_if.slave (stall/flush/cfg/in/out/status signals)
// Priority on each edge: rst > cfg_we > flush > stall > advance.
module delay_line_prog #(
    parameter int WIDTH         = 16,
    parameter int CHANNELS      = 4,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 10
) (
    input  logic             clk,
    input  logic             rst,
    delay_line_prog_if.slave bus
);
    localparam int DW     = $clog2(MAX_DELAY + 1);
    localparam int PW     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int DATA_W = CHANNELS * WIDTH;

    logic [DATA_W-1:0]    mem [MAX_DELAY];
    logic [MAX_DELAY-1:0] vld;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        wr_ptr_nxt;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        age_ptr;
    logic [DW-1:0]        cur_delay_r;
    logic [DW-1:0]        in_flight_r;
    logic [DW-1:0]        cfg_clamped;
    logic                 out_valid_r;
    logic [DATA_W-1:0]    out_data_r;
    logic                 advance;
    logic                 retire;

    // Position 'back' entries behind p, modulo MAX_DELAY (back is 0..MAX_DELAY).
    function automatic logic [PW-1:0] ptr_back(input logic [PW-1:0] p,
                                               input logic [DW-1:0] back);
        int t;
        t = int'(p) + MAX_DELAY - int'(back);
        if (t >= MAX_DELAY) begin
            t = t - MAX_DELAY;
        end
        return PW'(t);
    endfunction

    assign advance = !rst && !bus.stall && !bus.flush && !bus.cfg_we;

    assign wr_ptr_nxt = (wr_ptr == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr + PW'(1);

    // The entry written D advances ago is the one presented on this edge.
    // With D = MAX_DELAY this is wr_ptr itself; its old content is read
    // before the non-blocking write replaces it.
    assign rd_ptr = ptr_back(wr_ptr, cur_delay_r);

    // in_flight counts valid samples among the last D-1 writes (including
    // the one taken on this edge). The entry D-1 behind wr_ptr drops out of
    // that window now: it is the sample that will be presented next advance.
    // With D = 1 the window is empty, so the sample just taken retires at once.
    assign age_ptr = ptr_back(wr_ptr, cur_delay_r - DW'(1));
    assign retire  = (cur_delay_r == DW'(1)) ? bus.in_valid : vld[age_ptr];

    always_comb begin
        cfg_clamped = bus.cfg_delay;
        if (bus.cfg_delay == '0) begin
            cfg_clamped = DW'(1);
        end else if (bus.cfg_delay > DW'(MAX_DELAY)) begin
            cfg_clamped = DW'(MAX_DELAY);
        end
    end

    // Sample payload needs no reset: an entry is only ever read out under its valid bit.
    always_ff @(posedge clk) begin
        if (advance) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld         <= '0;
            wr_ptr      <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            in_flight_r <= '0;
            cur_delay_r <= DW'(DEFAULT_DELAY);
        end else if (bus.cfg_we) begin
            cur_delay_r <= cfg_clamped;
            vld         <= '0;
            out_valid_r <= 1'b0;
            in_flight_r <= '0;
        end else if (bus.flush) begin
            vld         <= '0;
            out_valid_r <= 1'b0;
            in_flight_r <= '0;
        end else if (!bus.stall) begin
            vld[wr_ptr] <= bus.in_valid;
            wr_ptr      <= wr_ptr_nxt;
            out_valid_r <= vld[rd_ptr];
            out_data_r  <= mem[rd_ptr];
            in_flight_r <= in_flight_r + DW'(bus.in_valid) - DW'(retire);
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.cur_delay = cur_delay_r;
    assign bus.in_flight = in_flight_r;
endmodule

// File: doc/delay_line_prog.md
DELAY_LINE_PROG -- requirements
Module: delay_line_prog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving data bits per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, giving the number of parallel lanes sharing one delay.
REQ-003 The block SHALL have parameter MAX_DELAY, default 16 (minimum 2), giving the largest programmable delay in cycles.
REQ-004 The block SHALL have parameter DEFAULT_DELAY, default 10, giving the delay after reset, within 1..MAX_DELAY.
REQ-005 clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 stall  input  1  freezes all delay-line state when high.
REQ-008 flush  input  1  invalidates every sample in flight.
REQ-009 cfg_we  input  1  loads cfg_delay as the new delay.
REQ-010 cfg_delay  input  $clog2(MAX_DELAY+1)  requested delay in cycles.
REQ-011 in_valid  input  1  qualifies in_data.
REQ-012 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 out_valid  output  1  qualifies out_data.
REQ-014 out_data  output  CHANNELS*WIDTH  delayed data, same lane packing.
REQ-015 cur_delay  output  $clog2(MAX_DELAY+1)  delay currently in effect.
REQ-016 in_flight  output  $clog2(MAX_DELAY+1)  count of accepted valid samples not yet presented.

Function
REQ-017 An advance SHALL occur on every rising edge where rst=0, stall=0, flush=0 and cfg_we=0.
REQ-018 On an advance, a sample with in_valid=1 SHALL appear on out_data with out_valid=1 exactly D advances later, where D=cur_delay; every lane shares the same D.
REQ-019 A slot sampled with in_valid=0 SHALL emerge with out_valid=0; out_data content is then don't-care.
REQ-020 Storage SHALL be a circular buffer of MAX_DELAY entries with per-entry valid bits, plus registered output; the read position is the write pointer minus D, modulo MAX_DELAY, and pointers wrap from MAX_DELAY-1 to 0.
REQ-021 While stall=1 (rst, flush and cfg_we low), pointers, valid bits, out_valid, out_data and in_flight SHALL hold, and in_data/in_valid SHALL be ignored.
REQ-022 flush=1 SHALL, on that edge, clear all entry valid bits, out_valid and in_flight, and leave cur_delay and the pointers unchanged; flush has priority over stall.
REQ-023 cfg_we=1 SHALL, on that edge, load cur_delay with cfg_delay clamped (0 -> 1, >MAX_DELAY -> MAX_DELAY) and perform the flush of REQ-022; cfg_we has priority over flush and stall.
REQ-024 in_data sampled on a flush or cfg_we edge SHALL be discarded.
REQ-025 in_flight SHALL change on an advance by +in_valid minus 1 if a valid sample becomes presented on that edge; it SHALL never exceed D-1 and SHALL never underflow.
REQ-026 With D=1, the block SHALL behave as a single register stage: out = previous-advance input, and in_flight remains 0.
REQ-027 The sequence seen on out_valid/out_data SHALL be independent of the pattern of interleaved stall cycles; only advances count toward the delay.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL clear all valid bits, pointers, out_valid, out_data (to 0) and in_flight, and SHALL set cur_delay=DEFAULT_DELAY; rst has priority over every other input.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight samples, so that no out_valid=1 appears until DEFAULT_DELAY advances after the first post-reset valid input.

Verification
REQ-030 Basic latency: reset, then in_valid=1 with lane0 data 0x0001..0x0014 on 20 consecutive cycles -> out_valid first high exactly 10 cycles after the first input, values 0x0001..0x0014 in order, in_flight peaks at 9.
REQ-031 Stall: D=4, inputs A,B,C on consecutive advances, stall high for 3 cycles after B -> outputs hold during stall; A,B,C each appear after exactly 4 advances.
REQ-032 Reconfigure: stream running at D=10, cfg_we with cfg_delay=3 -> out_valid=0 and in_flight=0 next cycle, cur_delay=3, next valid input appears 3 advances later; cfg_delay=0 yields cur_delay=1, cfg_delay=31 with MAX_DELAY=16 yields 16.
REQ-033 Flush with stall: 5 samples in flight, flush=1 and stall=1 on the same edge -> all cleared, no out_valid=1 for the old samples.
REQ-034 Wrap: D=MAX_DELAY=16, 40 continuous valid inputs -> every output matches its input 16 cycles earlier across pointer wrap, with all 4 lanes carrying distinct data.
REQ-035 Mid-run reset: rst high for 1 cycle with 6 samples in flight -> out_valid=0, in_flight=0, cur_delay=10, none of the 6 samples appear.
